pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the F/D, D/E and E/M buffers and the PC register. It resolves load-use hazards, taken-branch flushes and multi-cycle memory waits. It also sequences the three-cycle interrupt entry (push PC, push flags, jump to vector). The block sits beside the pipeline buffers and holds the only pipeline-control state in the core.

## Interface
- No parameters; register-address width (3) and phase encodings come from the shared package.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_src1, id_src2  in  3  source register addresses of the instruction in Decode
- id_use1, id_use2  in  1  Decode instruction actually reads src1/src2
- de_is_branch  in  1  instruction in D/E is a branch or jump
- ex_mem_read  in  1  instruction in Execute is a load
- ex_write_en  in  1  instruction in Execute writes the register file
- ex_write_add  in  3  destination register of the Execute instruction
- ex_branch_taken  in  1  branch resolved taken in Execute this cycle
- mem_busy  in  1  data memory has not completed this cycle
- intr  in  1  level interrupt request
- pc_en, fd_en, de_en, em_en  out  1  load enables for PC and the buffers
- fd_flush, de_flush  out  1  load a NOP/zero control word instead of input
- intr_phase  out  2  injected micro-op: 0 none, 1 push PC, 2 push flags, 3 load vector
- intr_ack  out  1  one-cycle acknowledge, high in the vector cycle

## Operation
- FSM states: RUN, INT_PC, INT_FLAGS, INT_JUMP.
- `pending` flag:
  - Set at any rising clock with intr=1.
  - Cleared on the RUN->INT_PC transition.
  - intr re-asserted during entry re-sets it.
- Load-use hazard (`lu`): ex_mem_read & ex_write_en & ((id_use1 & id_src1==ex_write_add) | (id_use2 & id_src2==ex_write_add)).
- Priority, highest first; applies in every state:
  1. mem_busy: pc_en=fd_en=de_en=em_en=0, both flushes 0, state and `pending` hold.
  2. RUN & ex_branch_taken: all enables 1, fd_flush=1, de_flush=1; `lu` ignored.
  3. RUN & lu: pc_en=0, fd_en=0, de_en=1 with de_flush=1 (one bubble), em_en=1.
  4. RUN & pending & !de_is_branch: go to INT_PC; outputs this cycle are normal RUN outputs.
  5. RUN otherwise: all enables 1, flushes 0, intr_phase=0.
- INT_PC: pc_en=0, fd_en=1, fd_flush=1, de_en=em_en=1, intr_phase=1; next INT_FLAGS.
- INT_FLAGS: same outputs with intr_phase=2; next INT_JUMP.
- INT_JUMP:
  - pc_en=1 (PC selects vector), fd_flush=1, intr_phase=3, intr_ack=1; next RUN.
  - ex_branch_taken in any INT state is ignored by the FSM; flushes are still governed by the state.

## Timing
- Reset (rst=0, asynchronous):
  - State RUN, pending=0.
  - Outputs forced to pc_en=fd_en=de_en=em_en=0, fd_flush=de_flush=1, intr_phase=0, intr_ack=0.
- Reset mid-entry aborts the sequence; no partial ack.
- Hazard, flush and busy outputs are combinational from inputs and state, with zero-cycle latency.
- Load-use costs exactly one bubble; the hazard clears naturally next cycle.
- Interrupt latency: intr sampled at edge N gives INT_PC during cycle N+1 (if RUN is unblocked), and intr_ack during cycle N+3.
- A stalled INT state stretches by the mem_busy duration; intr_ack stays single-cycle per unstalled INT_JUMP.
- With mem_busy and branch simultaneous, the freeze wins; the branch flush occurs in the first non-busy cycle (EX held).

## Structure
- Package pipe_ctrl_pkg:
  - typedef ctrl_state_t {RUN, INT_PC, INT_FLAGS, INT_JUMP}
  - constants INTR_NONE/PUSH_PC/PUSH_FLAGS/VECTOR (2 bits)
  - localparam REG_ADDR_W=3
- Sub-module hazard_detect: purely combinational `lu` compare, instantiated once.
- FSM, pending flag and output decode live in pipe_ctrl.

## Test plan
- Reset: hold rst=0, toggle clk → all enables 0, both flushes 1, intr_ack 0. Release rst → RUN outputs all enables 1.
- Load-use: ex_mem_read=1, ex_write_en=1, ex_write_add=3, id_use1=1, id_src1=3 → one cycle of pc_en=0, fd_en=0, de_flush=1. Same with id_use1=0 → no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 → fd_flush=de_flush=1 with pc_en=1, no stall.
- Interrupt: intr pulse at edge 5 → intr_phase 1,2,3 in cycles 6,7,8, intr_ack=1 only in cycle 8. With de_is_branch=1 at cycle 6, the sequence shifts one cycle later.
- mem_busy asserted 3 cycles during INT_FLAGS → all enables 0 for 3 cycles, intr_phase stays 2, then INT_JUMP. Exactly one intr_ack.
- Reset asserted during INT_FLAGS → immediate reset outputs. After release: RUN, pending=0, no intr_ack.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
//
// Contents:
//   REG_ADDR_W    register-file address width
//   ctrl_state_t  controller FSM states
//   INTR_*        injected interrupt micro-op encodings
//   phase_of()    maps a controller state to its intr_phase value

package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_PC    = 2'd1,
    INT_FLAGS = 2'd2,
    INT_JUMP  = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] INTR_NONE       = 2'd0;
  localparam logic [1:0] INTR_PUSH_PC    = 2'd1;
  localparam logic [1:0] INTR_PUSH_FLAGS = 2'd2;
  localparam logic [1:0] INTR_VECTOR     = 2'd3;

  // The injected micro-op follows the state directly, including while the
  // state is frozen by a memory wait.
  function automatic logic [1:0] phase_of(input ctrl_state_t s);
    logic [1:0] p;
    p = INTR_NONE;
    case (s)
      RUN:       p = INTR_NONE;
      INT_PC:    p = INTR_PUSH_PC;
      INT_FLAGS: p = INTR_PUSH_FLAGS;
      INT_JUMP:  p = INTR_VECTOR;
      default:   p = INTR_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Ports:
//   id_src1, id_src2   in   source registers of the Decode instruction
//   id_use1, id_use2   in   Decode instruction really reads src1/src2
//   ex_mem_read        in   Execute instruction is a load
//   ex_write_en        in   Execute instruction writes the register file
//   ex_write_add       in   destination register of the Execute instruction
//   lu                 out  Decode needs a value the Execute load has not produced

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  ex_mem_read,
  input  logic                  ex_write_en,
  input  logic [REG_ADDR_W-1:0] ex_write_add,
  output logic                  lu
);

  logic hit1;
  logic hit2;

  // Register 0 is not special here: a load into r0 still stalls a reader.
  assign hit1 = id_use1 && (id_src1 == ex_write_add);
  assign hit2 = id_use2 && (id_src2 == ex_write_add);
  assign lu   = ex_mem_read && ex_write_en && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with interrupt entry sequencer
//
// Ports:
//   clk, rst                    pipeline clock; asynchronous active-low reset
//   id_src1/2, id_use1/2        Decode operand addresses and use flags
//   de_is_branch                D/E instruction is a branch or jump
//   ex_mem_read, ex_write_en    Execute instruction is a load / writes regfile
//   ex_write_add                Execute destination register
//   ex_branch_taken             branch resolved taken in Execute
//   mem_busy                    data memory did not complete this cycle
//   intr                        level interrupt request
//   pc_en, fd_en, de_en, em_en  load enables for PC and pipeline buffers
//   fd_flush, de_flush          load a NOP control word into F/D, D/E
//   intr_phase                  injected micro-op (none/push PC/push flags/vector)
//   intr_ack                    single-cycle acknowledge in the vector cycle

module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  de_is_branch,
  input  logic                  ex_mem_read,
  input  logic                  ex_write_en,
  input  logic [REG_ADDR_W-1:0] ex_write_add,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  intr,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_en,
  output logic                  em_en,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic [1:0]            intr_phase,
  output logic                  intr_ack
);

  ctrl_state_t state, state_n;
  logic        pending, pending_n;
  logic        lu;

  hazard_detect u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .ex_mem_read  (ex_mem_read),
    .ex_write_en  (ex_write_en),
    .ex_write_add (ex_write_add),
    .lu           (lu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n    = state;
    pending_n  = pending | intr;
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    de_en      = 1'b1;
    em_en      = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    intr_phase = phase_of(state);
    intr_ack   = 1'b0;

    if (mem_busy) begin
      // Freeze everything, including a pending branch flush: EX is held, so
      // ex_branch_taken is still presented in the first non-busy cycle.
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      em_en     = 1'b0;
      pending_n = pending;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (lu) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
          end else if ((pending || intr) && !de_is_branch) begin
            // A request sampled at this edge enters directly so that INT_PC
            // follows the sampling edge; it is consumed by the transition.
            state_n   = INT_PC;
            pending_n = 1'b0;
          end
        end
        INT_PC: begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
          state_n  = INT_FLAGS;
        end
        INT_FLAGS: begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
          state_n  = INT_JUMP;
        end
        INT_JUMP: begin
          fd_flush = 1'b1;
          intr_ack = 1'b1;
          state_n  = RUN;
        end
        default: state_n = RUN;
      endcase
    end

    // While held in reset the buffers load bubbles and nothing advances.
    if (!rst) begin
      pc_en      = 1'b0;
      fd_en      = 1'b0;
      de_en      = 1'b0;
      em_en      = 1'b0;
      fd_flush   = 1'b1;
      de_flush   = 1'b1;
      intr_phase = INTR_NONE;
      intr_ack   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_src1, id_src2, ex_write_add;
  logic       id_use1, id_use2, de_is_branch, ex_mem_read, ex_write_en;
  logic       ex_branch_taken, mem_busy, intr;
  logic       pc_en, fd_en, de_en, em_en, fd_flush, de_flush, intr_ack;
  logic [1:0] intr_phase;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use1         (id_use1),
    .id_use2         (id_use2),
    .de_is_branch    (de_is_branch),
    .ex_mem_read     (ex_mem_read),
    .ex_write_en     (ex_write_en),
    .ex_write_add    (ex_write_add),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .intr            (intr),
    .pc_en           (pc_en),
    .fd_en           (fd_en),
    .de_en           (de_en),
    .em_en           (em_en),
    .fd_flush        (fd_flush),
    .de_flush        (de_flush),
    .intr_phase      (intr_phase),
    .intr_ack        (intr_ack)
  );

  // {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, intr_phase, intr_ack}
  logic [8:0] outs;
  assign outs = {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, intr_phase, intr_ack};

  localparam logic [8:0] E_RST   = {6'b000011, 2'd0, 1'b0};
  localparam logic [8:0] E_RUN   = {6'b111100, 2'd0, 1'b0};
  localparam logic [8:0] E_PC    = {6'b011110, 2'd1, 1'b0};
  localparam logic [8:0] E_FL    = {6'b011110, 2'd2, 1'b0};
  localparam logic [8:0] E_JMP   = {6'b111110, 2'd3, 1'b1};
  localparam logic [8:0] E_FL_BZ = {6'b000000, 2'd2, 1'b0};

  typedef struct {
    logic [2:0] s1, s2, wa;
    logic       u1, u2, br, mr, we, bt, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                              input logic u2, input logic mr, input logic we,
                              input logic [2:0] wa, input logic bt, input logic busy,
                              input logic [5:0] exp);
    vec_t v;
    v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2; v.br = 1'b0;
    v.mr = mr; v.we = we; v.wa = wa; v.bt = bt; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_src1 = 3'd0; id_src2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    de_is_branch = 1'b0; ex_mem_read = 1'b0; ex_write_en = 1'b0;
    ex_write_add = 3'd0; ex_branch_taken = 1'b0; mem_busy = 1'b0; intr = 1'b0;
  endtask

  // Pulse intr for one edge; afterwards the DUT is in INT_PC.
  task automatic enter_intr();
    @(negedge clk); intr = 1'b1;
    @(negedge clk); intr = 1'b0;
  endtask

  initial begin
    int acks;
    idle_inputs();
    rst = 1'b0;

    // Reset held across edges
    repeat (2) @(negedge clk);
    #1 check("reset_hold", outs, E_RST);
    @(negedge clk); rst = 1'b1;
    #1 check("reset_release_run", outs, E_RUN);

    // Combinational table in RUN with no interrupt
    //              s1    u1  s2    u2  mr  we  wa    bt  busy exp
    tbl[0]  = mk(3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 6'b111100);
    tbl[1]  = mk(3'd3, 1, 3'd0, 0, 1, 1, 3'd3, 0, 0, 6'b001101);
    tbl[2]  = mk(3'd3, 0, 3'd0, 0, 1, 1, 3'd3, 0, 0, 6'b111100);
    tbl[3]  = mk(3'd1, 0, 3'd5, 1, 1, 1, 3'd5, 0, 0, 6'b001101);
    tbl[4]  = mk(3'd3, 1, 3'd0, 0, 0, 1, 3'd3, 0, 0, 6'b111100);
    tbl[5]  = mk(3'd3, 1, 3'd0, 0, 1, 0, 3'd3, 0, 0, 6'b111100);
    tbl[6]  = mk(3'd2, 1, 3'd4, 1, 1, 1, 3'd3, 0, 0, 6'b111100);
    tbl[7]  = mk(3'd3, 1, 3'd0, 0, 1, 1, 3'd3, 1, 0, 6'b111111);
    tbl[8]  = mk(3'd3, 1, 3'd0, 0, 1, 1, 3'd3, 0, 1, 6'b000000);
    tbl[9]  = mk(3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 6'b000000);
    tbl[10] = mk(3'd0, 1, 3'd6, 0, 1, 1, 3'd0, 0, 0, 6'b001101);
    tbl[11] = mk(3'd6, 0, 3'd7, 1, 1, 1, 3'd7, 0, 0, 6'b001101);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_src1 = tbl[i].s1; id_use1 = tbl[i].u1;
      id_src2 = tbl[i].s2; id_use2 = tbl[i].u2;
      de_is_branch = tbl[i].br; ex_mem_read = tbl[i].mr; ex_write_en = tbl[i].we;
      ex_write_add = tbl[i].wa; ex_branch_taken = tbl[i].bt; mem_busy = tbl[i].busy;
      #1 check($sformatf("vec%0d", i), outs, {tbl[i].exp, 2'd0, 1'b0});
    end
    @(negedge clk); idle_inputs();
    #1 check("table_exit_run", outs, E_RUN);

    // Branch held through a freeze: flush appears in the first non-busy cycle
    @(negedge clk); ex_branch_taken = 1'b1; mem_busy = 1'b1;
    #1 check("busy_branch_freeze", outs, {6'b000000, 2'd0, 1'b0});
    @(negedge clk); mem_busy = 1'b0;
    #1 check("branch_after_busy", outs, {6'b111111, 2'd0, 1'b0});
    @(negedge clk); idle_inputs();

    // Interrupt entry: phases 1,2,3 then back to RUN
    enter_intr();
    #1 check("int_pc", outs, E_PC);
    @(negedge clk); #1 check("int_flags", outs, E_FL);
    @(negedge clk); #1 check("int_jump", outs, E_JMP);
    @(negedge clk); #1 check("int_done_run", outs, E_RUN);
    @(negedge clk); #1 check("int_no_retrigger", outs, E_RUN);

    // Branch in D/E blocks entry for one cycle; pending carries it
    @(negedge clk); intr = 1'b1; de_is_branch = 1'b1;
    @(negedge clk); intr = 1'b0; de_is_branch = 1'b0;
    #1 check("br_delay_still_run", outs, E_RUN);
    @(negedge clk); #1 check("br_delay_int_pc", outs, E_PC);
    @(negedge clk); #1 check("br_delay_int_flags", outs, E_FL);
    @(negedge clk); #1 check("br_delay_int_jump", outs, E_JMP);
    @(negedge clk); #1 check("br_delay_run", outs, E_RUN);

    // Three busy cycles during INT_FLAGS
    acks = 0;
    enter_intr();
    if (intr_ack) acks++;
    @(negedge clk); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("flags_busy%0d", i), outs, E_FL_BZ);
      if (intr_ack) acks++;
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1 check("flags_after_busy", outs, E_FL);
    if (intr_ack) acks++;
    @(negedge clk); #1 check("jump_after_busy", outs, E_JMP);
    if (intr_ack) acks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (intr_ack) acks++;
    end
    check("busy_ack_count", 9'(acks), 9'd1);
    check("busy_seq_run", outs, E_RUN);

    // Asynchronous reset in INT_FLAGS aborts the entry
    enter_intr();
    @(negedge clk);
    #1 check("pre_reset_flags", outs, E_FL);
    #2 rst = 1'b0;
    #1 check("reset_mid_entry", outs, E_RST);
    @(negedge clk); rst = 1'b1;
    acks = 0;
    #1 check("reset_release_run2", outs, E_RUN);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (intr_ack || intr_phase != 2'd0) acks++;
    end
    check("no_entry_after_reset", 9'(acks), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
